// File: rtl/free_list_ctrl.sv
// Rename-side tag buffer and commit-side release queue in front of the physical-register free list.
// Latency: preallocated tags reach ren_phys* one cycle after the free_list response; a released tag reaches fl_free_phys one cycle after enqueue.
// Backpressure: ren_ready needs two buffered tags; cm_ready needs two free slots; both depend on registered counts only.
package core_pkg;
    localparam int PREGS = 64;
endpackage

module free_list_ctrl #(
    parameter int PHYS_REGS  = core_pkg::PREGS,
    parameter int PBUF_DEPTH = 4,
    parameter int FBUF_DEPTH = 4,
    localparam int TW  = $clog2(PHYS_REGS),
    localparam int PCW = $clog2(PBUF_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    ren_req,
    output logic          ren_ready,
    output logic [TW-1:0] ren_phys0,
    output logic [TW-1:0] ren_phys1,
    input  logic [1:0]    cm_free_en,
    input  logic [TW-1:0] cm_free_phys0,
    input  logic [TW-1:0] cm_free_phys1,
    output logic          cm_ready,
    output logic          fl_alloc_en,
    input  logic [TW-1:0] fl_alloc_phys,
    input  logic          fl_alloc_valid,
    output logic          fl_free_en,
    output logic [TW-1:0] fl_free_phys,
    output logic [PCW-1:0] pbuf_count
);
    localparam int PPW = $clog2(PBUF_DEPTH);
    localparam int FPW = $clog2(FBUF_DEPTH);
    localparam int FCW = FPW + 1;

    logic [TW-1:0]  pbuf [PBUF_DEPTH];
    logic [PPW-1:0] phead, ptail;
    logic [PCW-1:0] pcount;
    logic           pending;

    logic [TW-1:0]  fbuf [FBUF_DEPTH];
    logic [FPW-1:0] fhead, ftail;
    logic [FCW-1:0] fcount;

    logic           p_push;
    logic [1:0]     p_pops;
    logic           f_push0, f_push1, f_pop;

    // A response is only trusted when a request was actually issued last cycle.
    assign p_push      = pending & fl_alloc_valid;
    assign ren_ready   = pcount >= PCW'(2);
    assign p_pops      = ren_ready ? ({1'b0, ren_req[0]} + {1'b0, ren_req[1]}) : 2'd0;
    assign ren_phys0   = pbuf[phead];
    assign ren_phys1   = ren_req[0] ? pbuf[phead + PPW'(1)] : pbuf[phead];
    assign fl_alloc_en = reset &
                         (({1'b0, pcount} + (PCW+1)'(pending)) < (PCW+1)'(PBUF_DEPTH));
    assign pbuf_count  = pcount;

    assign cm_ready     = fcount <= FCW'(FBUF_DEPTH - 2);
    assign f_push0      = cm_ready & cm_free_en[0];
    assign f_push1      = cm_ready & cm_free_en[1];
    assign fl_free_en   = fcount != '0;
    assign fl_free_phys = fbuf[fhead];
    assign f_pop        = fl_free_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PBUF_DEPTH; i++) pbuf[i] <= '0;
            for (int i = 0; i < FBUF_DEPTH; i++) fbuf[i] <= '0;
            phead   <= '0;
            ptail   <= '0;
            pcount  <= '0;
            pending <= 1'b0;
            fhead   <= '0;
            ftail   <= '0;
            fcount  <= '0;
        end else begin
            pending <= fl_alloc_en;
            if (p_push) begin
                pbuf[ptail] <= fl_alloc_phys;
                ptail       <= ptail + PPW'(1);
            end
            phead  <= phead + PPW'(p_pops);
            pcount <= pcount + PCW'(p_push) - PCW'(p_pops);

            // Slot 1 lands behind slot 0 when both release together.
            if (f_push0) fbuf[ftail] <= cm_free_phys0;
            if (f_push1) fbuf[ftail + FPW'(f_push0)] <= cm_free_phys1;
            ftail  <= ftail + FPW'(f_push0) + FPW'(f_push1);
            fhead  <= fhead + FPW'(f_pop);
            fcount <= fcount + FCW'(f_push0) + FCW'(f_push1) - FCW'(f_pop);
        end
    end
endmodule

// File: tb/tb_free_list_ctrl.sv
// Directed bench for free_list_ctrl: inputs change 1 time unit after the rising edge, outputs are checked on the falling edge.
module tb_free_list_ctrl;
    logic       clk;
    logic       reset;
    logic [1:0] ren_req;
    logic       ren_ready;
    logic [5:0] ren_phys0, ren_phys1;
    logic [1:0] cm_free_en;
    logic [5:0] cm_free_phys0, cm_free_phys1;
    logic       cm_ready;
    logic       fl_alloc_en;
    logic [5:0] fl_alloc_phys;
    logic       fl_alloc_valid;
    logic       fl_free_en;
    logic [5:0] fl_free_phys;
    logic [2:0] pbuf_count;

    int n_tests = 0;
    int n_fail  = 0;

    free_list_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .ren_req        (ren_req),
        .ren_ready      (ren_ready),
        .ren_phys0      (ren_phys0),
        .ren_phys1      (ren_phys1),
        .cm_free_en     (cm_free_en),
        .cm_free_phys0  (cm_free_phys0),
        .cm_free_phys1  (cm_free_phys1),
        .cm_ready       (cm_ready),
        .fl_alloc_en    (fl_alloc_en),
        .fl_alloc_phys  (fl_alloc_phys),
        .fl_alloc_valid (fl_alloc_valid),
        .fl_free_en     (fl_free_en),
        .fl_free_phys   (fl_free_phys),
        .pbuf_count     (pbuf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ren_ready"},   32'(ren_ready),    32'd0);
        chk({tag, "_cm_ready"},    32'(cm_ready),     32'd1);
        chk({tag, "_alloc_en"},    32'(fl_alloc_en),  32'd0);
        chk({tag, "_free_en"},     32'(fl_free_en),   32'd0);
        chk({tag, "_pbuf_count"},  32'(pbuf_count),   32'd0);
        chk({tag, "_ren_phys0"},   32'(ren_phys0),    32'd0);
        chk({tag, "_ren_phys1"},   32'(ren_phys1),    32'd0);
        chk({tag, "_free_phys"},   32'(fl_free_phys), 32'd0);
    endtask

    initial begin
        reset = 1'b0; ren_req = 2'b00; cm_free_en = 2'b00;
        cm_free_phys0 = '0; cm_free_phys1 = '0;
        fl_alloc_phys = '0; fl_alloc_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("rst");

        // Release; a response in this first cycle must be ignored.
        tick(); reset = 1'b1; fl_alloc_valid = 1'b1; fl_alloc_phys = 6'd63;
        @(negedge clk);
        chk("c1_alloc_en", 32'(fl_alloc_en), 32'd1);

        tick(); fl_alloc_phys = 6'd10;
        @(negedge clk);
        chk("c2_alloc_en", 32'(fl_alloc_en), 32'd1);
        chk("c2_count",    32'(pbuf_count),  32'd0);

        tick(); fl_alloc_phys = 6'd11;
        @(negedge clk);
        chk("c3_count",    32'(pbuf_count),  32'd1);
        chk("c3_alloc_en", 32'(fl_alloc_en), 32'd1);
        chk("c3_ren_rdy",  32'(ren_ready),   32'd0);

        tick(); fl_alloc_phys = 6'd12;
        @(negedge clk);
        chk("c4_count",    32'(pbuf_count),  32'd2);
        chk("c4_ren_rdy",  32'(ren_ready),   32'd1);
        chk("c4_alloc_en", 32'(fl_alloc_en), 32'd1);

        tick(); fl_alloc_phys = 6'd13;
        @(negedge clk);
        chk("c5_count",    32'(pbuf_count),  32'd3);
        chk("c5_alloc_en", 32'(fl_alloc_en), 32'd0);
        chk("c5_phys1_noreq", 32'(ren_phys1), 32'd10);

        // Two double pops from a full buffer.
        tick(); fl_alloc_valid = 1'b0; ren_req = 2'b11;
        @(negedge clk);
        chk("c6_count",    32'(pbuf_count),  32'd4);
        chk("c6_alloc_en", 32'(fl_alloc_en), 32'd0);
        chk("c6_phys0",    32'(ren_phys0),   32'd10);
        chk("c6_phys1",    32'(ren_phys1),   32'd11);

        tick();
        @(negedge clk);
        chk("c7_count",    32'(pbuf_count),  32'd2);
        chk("c7_phys0",    32'(ren_phys0),   32'd12);
        chk("c7_phys1",    32'(ren_phys1),   32'd13);
        chk("c7_alloc_en", 32'(fl_alloc_en), 32'd1);

        // Empty free_list: requests keep going, nothing pushed.
        tick(); ren_req = 2'b00;
        @(negedge clk);
        chk("c8_count",    32'(pbuf_count),  32'd0);
        chk("c8_ren_rdy",  32'(ren_ready),   32'd0);
        chk("c8_alloc_en", 32'(fl_alloc_en), 32'd1);

        tick();
        @(negedge clk);
        chk("c9_count",    32'(pbuf_count),  32'd0);
        chk("c9_alloc_en", 32'(fl_alloc_en), 32'd1);

        tick(); fl_alloc_valid = 1'b1; fl_alloc_phys = 6'd20;
        @(negedge clk);
        chk("c10_count", 32'(pbuf_count), 32'd0);

        tick(); fl_alloc_phys = 6'd21;
        @(negedge clk);
        chk("c11_count", 32'(pbuf_count), 32'd1);

        // Slot-1-only request takes the head tag.
        tick(); fl_alloc_valid = 1'b0; ren_req = 2'b10;
        @(negedge clk);
        chk("c12_count", 32'(pbuf_count), 32'd2);
        chk("c12_phys1", 32'(ren_phys1),  32'd20);

        // Requests while not ready are ignored.
        tick(); ren_req = 2'b11;
        @(negedge clk);
        chk("c13_count",   32'(pbuf_count), 32'd1);
        chk("c13_ren_rdy", 32'(ren_ready),  32'd0);
        chk("c13_phys0",   32'(ren_phys0),  32'd21);

        tick(); ren_req = 2'b00;
        @(negedge clk);
        chk("c14_count", 32'(pbuf_count), 32'd1);
        chk("c14_phys0", 32'(ren_phys0),  32'd21);

        // Commit releases (5,7) accepted three times.
        tick(); cm_free_en = 2'b11; cm_free_phys0 = 6'd5; cm_free_phys1 = 6'd7;
        @(negedge clk);
        chk("f1_cm_ready", 32'(cm_ready),   32'd1);
        chk("f1_free_en",  32'(fl_free_en), 32'd0);

        tick();
        @(negedge clk);
        chk("f2_cm_ready", 32'(cm_ready),     32'd1);
        chk("f2_free_en",  32'(fl_free_en),   32'd1);
        chk("f2_phys",     32'(fl_free_phys), 32'd5);

        tick();
        @(negedge clk);
        chk("f3_cm_ready", 32'(cm_ready),     32'd0);
        chk("f3_phys",     32'(fl_free_phys), 32'd7);

        tick();
        @(negedge clk);
        chk("f4_cm_ready", 32'(cm_ready),     32'd1);
        chk("f4_phys",     32'(fl_free_phys), 32'd5);

        tick(); cm_free_en = 2'b00;
        @(negedge clk);
        chk("f5_cm_ready", 32'(cm_ready),     32'd0);
        chk("f5_phys",     32'(fl_free_phys), 32'd7);

        tick();
        @(negedge clk);
        chk("f6_phys", 32'(fl_free_phys), 32'd5);

        tick();
        @(negedge clk);
        chk("f7_phys",    32'(fl_free_phys), 32'd7);
        chk("f7_free_en", 32'(fl_free_en),   32'd1);

        tick();
        @(negedge clk);
        chk("f8_free_en",  32'(fl_free_en), 32'd0);
        chk("f8_cm_ready", 32'(cm_ready),   32'd1);

        // Build count=3, fcount=2, pending=1, then reset mid-cycle.
        tick(); fl_alloc_valid = 1'b1; fl_alloc_phys = 6'd30;
        @(negedge clk);
        chk("g1_count", 32'(pbuf_count), 32'd1);

        tick(); fl_alloc_phys = 6'd31;
        cm_free_en = 2'b11; cm_free_phys0 = 6'd8; cm_free_phys1 = 6'd9;
        @(negedge clk);
        chk("g2_count", 32'(pbuf_count), 32'd2);

        tick(); fl_alloc_valid = 1'b0; cm_free_en = 2'b00;
        @(negedge clk);
        chk("g3_count",    32'(pbuf_count),   32'd3);
        chk("g3_free_phys",32'(fl_free_phys), 32'd8);
        chk("g3_cm_ready", 32'(cm_ready),     32'd1);
        chk("g3_alloc_en", 32'(fl_alloc_en),  32'd0);
        #1 reset = 1'b0;
        #1 chk_reset_outputs("midrst");

        tick(); reset = 1'b1; fl_alloc_valid = 1'b1; fl_alloc_phys = 6'd40;
        @(negedge clk);
        chk("r1_alloc_en", 32'(fl_alloc_en), 32'd1);
        chk("r1_count",    32'(pbuf_count),  32'd0);

        tick(); fl_alloc_valid = 1'b0;
        @(negedge clk);
        chk("r2_count",   32'(pbuf_count), 32'd0);
        chk("r2_free_en", 32'(fl_free_en), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/free_list_ctrl.md
FREE_LIST_CTRL -- requirements
Module: free_list_ctrl

Interface
REQ-001 Parameter PHYS_REGS, default core_pkg::PREGS, number of physical registers; tag width is $clog2(PHYS_REGS), 6 at default.
REQ-002 Parameter PBUF_DEPTH, default 4, depth of the preallocated-tag buffer (power of two, >=2).
REQ-003 Parameter FBUF_DEPTH, default 4, depth of the pending-free FIFO (power of two, >=2).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 ren_req  in  2  bit i = rename slot i needs a destination tag this cycle.
REQ-007 ren_ready  out  1  both rename slots may be served this cycle.
REQ-008 ren_phys0  out  6  tag for slot 0.
REQ-009 ren_phys1  out  6  tag for slot 1.
REQ-010 cm_free_en  in  2  bit i = commit slot i releases a tag.
REQ-011 cm_free_phys0  in  6  tag released by commit slot 0.
REQ-012 cm_free_phys1  in  6  tag released by commit slot 1.
REQ-013 cm_ready  out  1  pending-free FIFO can accept two tags this cycle.
REQ-014 fl_alloc_en  out  1  allocation request to free_list.
REQ-015 fl_alloc_phys  in  6  free_list tag, valid one cycle after fl_alloc_en.
REQ-016 fl_alloc_valid  in  1  free_list response qualifier, same cycle as fl_alloc_phys.
REQ-017 fl_free_en  out  1  free request to free_list.
REQ-018 fl_free_phys  out  6  tag being freed.
REQ-019 pbuf_count  out  3  tags currently held in the preallocated buffer.

Function
REQ-020 Preallocated buffer: circular FIFO of PBUF_DEPTH tags with head, tail, count; wraps modulo PBUF_DEPTH.
REQ-021 pending = fl_alloc_en registered; marks a free_list response due this cycle.
REQ-022 fl_alloc_en = reset high AND (count + pending) < PBUF_DEPTH; combinational from registered state; never overfills.
REQ-023 Cycle with pending=1 and fl_alloc_valid=1: fl_alloc_phys pushed at tail; pending=1 with fl_alloc_valid=0: nothing pushed, no retry state kept.
REQ-024 ren_ready = (count >= 2), from registered count only, independent of ren_req.
REQ-025 ren_phys0 = buf[head]; ren_phys1 = buf[head+1] when ren_req[0]=1, else buf[head].
REQ-026 Pop when ren_ready=1: count decreases by popcount(ren_req); head advances by same; ren_req ignored when ren_ready=0.
REQ-027 Same-cycle push and pop: count_next = count + push - pops; a pushed tag is never visible on ren_phys* the cycle it arrives.
REQ-028 Pending-free FIFO: circular FIFO of FBUF_DEPTH tags; cm_ready = (FBUF_DEPTH - fcount) >= 2, from registered state.
REQ-029 When cm_ready=1, enqueue cm_free_phys0 then cm_free_phys1 per cm_free_en bits, slot 0 first; when cm_ready=0, cm_free_en is ignored (upstream holds).
REQ-030 fl_free_en = (fcount != 0); fl_free_phys = fbuf[fhead]; one tag dequeued every cycle fl_free_en=1.
REQ-031 Simultaneous two enqueues and one dequeue: fcount_next = fcount + 2 - 1; tag order preserved.
REQ-032 Freed tags never bypass into the preallocated buffer; all reuse goes through free_list.
REQ-033 No tag duplicated or lost: every accepted fl_alloc_phys leaves exactly once on ren_phys*, every accepted cm_free tag leaves exactly once on fl_free_phys.

Reset
REQ-034 reset low, asynchronously: count=0, fcount=0, heads/tails=0, pending=0; outputs ren_ready=0, cm_ready=1, fl_alloc_en=0, fl_free_en=0, pbuf_count=0, ren_phys*=0, fl_free_phys=0.
REQ-035 Reset asserted mid-operation discards buffered and in-flight tags; a free_list response arriving in the first cycle after release is ignored (pending=0).
REQ-036 First cycle after release: fl_alloc_en=1.

Verification
REQ-037 Release reset, model returns 10,11,12,13 -> fl_alloc_en high cycles 1-4, low after; pbuf_count=4; ren_ready=1 from count=2.
REQ-038 count=4 (10..13), ren_req=2'b11 two cycles -> (10,11) then (12,13); refill restarts the cycle after first pop.
REQ-039 ren_req=2'b10, count=2 -> ren_phys1=head tag, count drops to 1, ren_ready=0 next cycle.
REQ-040 Model fl_alloc_valid=0 (empty) -> pbuf_count stays, fl_alloc_en keeps asserting, no spurious push.
REQ-041 cm_free_en=2'b11 with (5,7) three consecutive cycles -> cm_ready drops at fcount>=3; fl_free_phys sequence 5,7,5,... one per cycle, none dropped.
REQ-042 Assert reset with count=3, fcount=2, pending=1 -> all outputs at REQ-034 values immediately; following response ignored.
